// File: rtl/ex_operand_b_stage.sv
// EX-stage ALU operand-B select: forwarding mux, immediate extension and ID/EX capture register.
// Optional stall counter output enabled by defining EX_OPB_STALL_CNT_EN.
module ex_operand_b_stage #(
   parameter int DATA_W  = 32,
   parameter int IMM_W   = 16,
   parameter int NUM_FWD = 2,
   parameter int SEL_W   = 3
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic                      Valid_ID,
   input  logic [DATA_W-1:0]         Read_Data_B_ID,
   input  logic [NUM_FWD*DATA_W-1:0] Fwd_Data_ID,
   input  logic [SEL_W-1:0]          Fwd_Sel_ID,
   input  logic [IMM_W-1:0]          Imm_ID,
   input  logic [1:0]                ALUSrc_Mode_ID,
   input  logic                      Stall,
   input  logic                      Flush,
   output logic [DATA_W-1:0]         ALU_Data_2_EX,
   output logic [DATA_W-1:0]         Store_Data_EX,
`ifdef EX_OPB_STALL_CNT_EN
   output logic [15:0]               Stall_Count_EX,
`endif
   output logic                      Valid_EX
);

   localparam int EXT_W = DATA_W - IMM_W;

   logic [DATA_W-1:0] w_fwd_b;
   logic [DATA_W-1:0] w_op_b;
   logic [DATA_W-1:0] r_alu_b;
   logic [DATA_W-1:0] r_store;
   logic              r_valid;

   // Out-of-range selects fall back to the register file so the mux never yields X.
   always_comb begin
      w_fwd_b = Read_Data_B_ID;
      for (int k = 0; k < NUM_FWD; k++) begin
         if (Fwd_Sel_ID == SEL_W'(k + 1)) begin
            w_fwd_b = Fwd_Data_ID[k*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      w_op_b = w_fwd_b;
      case (ALUSrc_Mode_ID)
         2'b01:   w_op_b = {{EXT_W{Imm_ID[IMM_W-1]}}, Imm_ID};
         2'b10:   w_op_b = {{EXT_W{1'b0}}, Imm_ID};
         2'b11:   w_op_b = {Imm_ID, {EXT_W{1'b0}}};
         default: w_op_b = w_fwd_b;
      endcase
   end

   // Flush outranks Stall; a bubble still captures its data fields.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_alu_b <= '0;
         r_store <= '0;
         r_valid <= 1'b0;
      end else if (Flush) begin
         r_alu_b <= '0;
         r_store <= '0;
         r_valid <= 1'b0;
      end else if (!Stall) begin
         r_alu_b <= w_op_b;
         r_store <= w_fwd_b;
         r_valid <= Valid_ID;
      end
   end

   assign ALU_Data_2_EX = r_alu_b;
   assign Store_Data_EX = r_store;
   assign Valid_EX      = r_valid;

`ifdef EX_OPB_STALL_CNT_EN
   logic [15:0] r_stall_cnt;

   // Saturating count of held cycles; a flushed edge is not a stall.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_stall_cnt <= '0;
      end else if (Stall && !Flush && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign Stall_Count_EX = r_stall_cnt;
`endif

endmodule
